// File: rtl/uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// uart_tx_fifo
// Transmit-side byte buffer placed directly in front of the UART transmitter.
// Bytes arrive from the bus side on a valid/ready handshake and leave
// first-word-fall-through on the transmitter handshake. The block also
// reports its occupancy, a sticky overflow flag and a low-watermark
// interrupt that software uses to refill the buffer.
//
// Ports
//   clk_i         clock, all logic on the rising edge
//   rst_i         synchronous active-high reset (highest priority)
//   clr_i         synchronous flush pulse (beats push and pop)
//   data_i        write data from the bus side
//   valid_i       write request
//   ready_o       buffer can accept (not full)
//   data_o        head entry, combinational read of registered state
//   valid_o       buffer not empty
//   ready_i       transmitter accepts the head entry
//   elements_o    occupancy, 0..BUFFER_DEPTH
//   cfg_thresh_i  low-watermark level
//   cfg_irq_en_i  low-watermark interrupt enable
//   irq_o         level interrupt: enabled and occupancy below threshold
//   overflow_o    sticky: a write was attempted while full
// ---------------------------------------------------------------------------
module uart_tx_fifo #(
    parameter int  DATA_WIDTH   = 8,
    parameter int  BUFFER_DEPTH = 16,
    localparam int LOG_DEPTH    = $clog2(BUFFER_DEPTH)
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic                  clr_i,
    input  logic [DATA_WIDTH-1:0] data_i,
    input  logic                  valid_i,
    output logic                  ready_o,
    output logic [DATA_WIDTH-1:0] data_o,
    output logic                  valid_o,
    input  logic                  ready_i,
    output logic [LOG_DEPTH:0]    elements_o,
    input  logic [LOG_DEPTH:0]    cfg_thresh_i,
    input  logic                  cfg_irq_en_i,
    output logic                  irq_o,
    output logic                  overflow_o
);

    localparam logic [LOG_DEPTH:0]   FULL_COUNT = (LOG_DEPTH+1)'(BUFFER_DEPTH);
    localparam logic [LOG_DEPTH:0]   ZERO_COUNT = (LOG_DEPTH+1)'(1'b0);
    localparam logic [LOG_DEPTH:0]   ONE_COUNT  = (LOG_DEPTH+1)'(1'b1);
    localparam logic [LOG_DEPTH-1:0] ZERO_PTR   = LOG_DEPTH'(1'b0);
    localparam logic [LOG_DEPTH-1:0] ONE_PTR    = LOG_DEPTH'(1'b1);

    logic [DATA_WIDTH-1:0] mem_r [BUFFER_DEPTH];
    logic [LOG_DEPTH-1:0]  rd_ptr_r;
    logic [LOG_DEPTH-1:0]  wr_ptr_r;
    logic [LOG_DEPTH:0]    elements_r;
    logic                  overflow_r;

    logic                  full_s;
    logic                  empty_s;
    logic                  push_s;
    logic                  pop_s;

    // Handshake qualifiers. ready_o is derived from the count only, so there
    // is no combinational path from ready_i back to ready_o.
    assign full_s  = (elements_r == FULL_COUNT);
    assign empty_s = (elements_r == ZERO_COUNT);
    assign push_s  = valid_i & ~full_s;
    assign pop_s   = ready_i & ~empty_s;

    assign ready_o    = ~full_s;
    assign valid_o    = ~empty_s;
    assign data_o     = mem_r[rd_ptr_r];
    assign elements_o = elements_r;
    assign overflow_o = overflow_r;
    // cfg inputs act combinationally; a zero threshold can never fire.
    assign irq_o      = cfg_irq_en_i & (elements_r < cfg_thresh_i);

    // Storage write port; array contents are deliberately left unreset.
    always_ff @(posedge clk_i) begin
        if (!rst_i && !clr_i && push_s) begin
            mem_r[wr_ptr_r] <= data_i;
        end
    end

    // Pointer, occupancy and sticky overflow state; reset beats flush,
    // flush beats any concurrent push or pop.
    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            rd_ptr_r   <= ZERO_PTR;
            wr_ptr_r   <= ZERO_PTR;
            elements_r <= ZERO_COUNT;
            overflow_r <= 1'b0;
        end else if (clr_i) begin
            rd_ptr_r   <= ZERO_PTR;
            wr_ptr_r   <= ZERO_PTR;
            elements_r <= ZERO_COUNT;
            overflow_r <= 1'b0;
        end else begin
            if (push_s) begin
                wr_ptr_r <= wr_ptr_r + ONE_PTR;
            end
            if (pop_s) begin
                rd_ptr_r <= rd_ptr_r + ONE_PTR;
            end
            case ({push_s, pop_s})
                2'b10:   elements_r <= elements_r + ONE_COUNT;
                2'b01:   elements_r <= elements_r - ONE_COUNT;
                default: elements_r <= elements_r;
            endcase
            // A write attempt against a full buffer is dropped but remembered.
            if (valid_i && full_s) begin
                overflow_r <= 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// ---------------------------------------------------------------------------
// tb_uart_tx_fifo
// Directed and randomised stimulus for uart_tx_fifo. Expected behaviour comes
// from a queue-based reference model: the queue holds the buffered bytes,
// its size is the occupancy and a bit holds the sticky overflow state.
// ---------------------------------------------------------------------------
module tb_uart_tx_fifo;

    localparam int DEPTH = 16;

    logic       clk_i = 1'b0;
    logic       rst_i = 1'b0;
    logic       clr_i = 1'b0;
    logic [7:0] data_i = 8'h00;
    logic       valid_i = 1'b0;
    logic       ready_o;
    logic [7:0] data_o;
    logic       valid_o;
    logic       ready_i = 1'b0;
    logic [4:0] elements_o;
    logic [4:0] cfg_thresh_i = 5'd4;
    logic       cfg_irq_en_i = 1'b1;
    logic       irq_o;
    logic       overflow_o;

    uart_tx_fifo dut (
        .clk_i        (clk_i),
        .rst_i        (rst_i),
        .clr_i        (clr_i),
        .data_i       (data_i),
        .valid_i      (valid_i),
        .ready_o      (ready_o),
        .data_o       (data_o),
        .valid_o      (valid_o),
        .ready_i      (ready_i),
        .elements_o   (elements_o),
        .cfg_thresh_i (cfg_thresh_i),
        .cfg_irq_en_i (cfg_irq_en_i),
        .irq_o        (irq_o),
        .overflow_o   (overflow_o)
    );

    always #5 clk_i = ~clk_i;

    // Reference model state
    logic [7:0] model_q[$];
    bit         model_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_all();
        int  sz;
        bit  exp_irq;
        sz      = model_q.size();
        exp_irq = cfg_irq_en_i && (sz < int'(cfg_thresh_i));
        chk("elements", 32'(elements_o), 32'(sz));
        chk("elem_bound", 32'(elements_o <= 5'd16), 32'd1);
        chk("ready", 32'(ready_o), 32'(sz != DEPTH));
        chk("valid", 32'(valid_o), 32'(sz != 0));
        chk("overflow", 32'(overflow_o), 32'(model_ovf));
        chk("irq", 32'(irq_o), 32'(exp_irq));
        if (sz > 0) begin
            chk("data", 32'(data_o), 32'(model_q[0]));
        end
    endtask

    // One clock: drive inputs, advance model by the buffering rules, check.
    task automatic step(input logic v, input logic [7:0] d, input logic r,
                        input logic c, input logic rs);
        bit full;
        bit pu;
        bit po;
        valid_i = v;
        data_i  = d;
        ready_i = r;
        clr_i   = c;
        rst_i   = rs;
        @(posedge clk_i);
        if (rs || c) begin
            model_q.delete();
            model_ovf = 1'b0;
        end else begin
            full = (model_q.size() == DEPTH);
            pu   = v && !full;
            po   = r && (model_q.size() > 0);
            if (v && full) model_ovf = 1'b1;
            if (po) void'(model_q.pop_front());
            if (pu) model_q.push_back(d);
        end
        #1;
        check_all();
    endtask

    initial begin
        int pushed;
        byte unsigned next_byte;
        bit v;
        bit r;

        model_q.delete();
        model_ovf = 1'b0;

        // Reset
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Single byte, FWFT latency, then pop
        step(1'b1, 8'h55, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        // Fill to full, overflow attempt, drain
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hAA, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Random stream with wrap-around
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        pushed    = 0;
        next_byte = 8'($urandom);
        for (int cyc = 0; cyc < 2000 && pushed < 40; cyc++) begin
            v = 1'($urandom_range(0, 1));
            r = 1'($urandom_range(0, 1));
            if (v && model_q.size() < DEPTH) begin
                step(v, next_byte, r, 1'b0, 1'b0);
                pushed++;
                next_byte = 8'($urandom);
            end else begin
                step(v, next_byte, r, 1'b0, 1'b0);
            end
        end
        chk("stream_done", 32'(pushed >= 40), 32'd1);
        for (int cyc = 0; cyc < 200 && model_q.size() > 0; cyc++) begin
            step(1'b0, 8'h00, 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        end
        chk("stream_drained", 32'(model_q.size()), 32'd0);

        // Full with simultaneous push and pop: pop only, then push accepted
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h30 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hE1, 1'b1, 1'b0, 1'b0);
        step(1'b1, 8'hE2, 1'b0, 1'b0, 1'b0);
        chk("full_again", 32'(elements_o), 32'd16);

        // Low-watermark interrupt
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < 5; i++) step(1'b1, 8'(8'h60 + i), 1'b0, 1'b0, 1'b0);
        cfg_thresh_i = 5'd4;
        cfg_irq_en_i = 1'b1;
        #1;
        check_all();
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("irq_low", 32'(irq_o), 32'd1);
        cfg_irq_en_i = 1'b0;
        #1;
        check_all();
        cfg_irq_en_i = 1'b1;
        cfg_thresh_i = 5'd0;
        #1;
        check_all();
        cfg_thresh_i = 5'd20;
        #1;
        check_all();
        cfg_thresh_i = 5'd4;

        // Flush beats concurrent push/pop, clears overflow
        step(1'b0, 8'h00, 1'b0, 1'b1, 1'b0);
        for (int i = 0; i < DEPTH; i++) step(1'b1, 8'(8'h80 + i), 1'b0, 1'b0, 1'b0);
        step(1'b1, 8'hBB, 1'b0, 1'b0, 1'b0);
        for (int i = 0; i < 9; i++) step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);
        chk("seven_left", 32'(elements_o), 32'd7);
        step(1'b1, 8'hCC, 1'b1, 1'b1, 1'b0);
        step(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        // Reset mid-stream, beating a concurrent flush
        for (int i = 0; i < 6; i++) step(1'b1, 8'($urandom), 1'($urandom_range(0, 1)), 1'b0, 1'b0);
        step(1'b1, 8'h11, 1'b1, 1'b1, 1'b1);
        step(1'b1, 8'h22, 1'b0, 1'b0, 1'b0);
        step(1'b0, 8'h00, 1'b1, 1'b0, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
